// File: rtl/assoc_cache_if.sv
// Request and memory bus bundle for assoc_cache.
// master = requester plus memory model side, slave = the cache.
interface assoc_cache_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              stall;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_valid, mem_rdata,
    input  rd_data, stall, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_valid, mem_rdata,
    output rd_data, stall, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/assoc_cache.sv
// 1/2-way set-associative write-through, no-write-allocate cache with block fill.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int WAYS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  assoc_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WSEL_W = $clog2(WORDS);
  localparam int OFF_W  = WSEL_W + 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W  = WSEL_W + 1;
  localparam logic [CNT_W-1:0] NWORDS = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LASTW  = CNT_W'(WORDS - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [WAY_W-1:0]  r_victim;
  logic [CNT_W-1:0]  r_issue;
  logic [CNT_W-1:0]  r_beat;
  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_rd_addr;
  logic              r_valid [WAYS][SETS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [DATA_W-1:0] r_data  [WAYS][SETS*WORDS];
  logic              r_lru   [SETS];

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_wsel;
  logic [IDX_W-1:0]  w_bidx;
  logic [TAG_W-1:0]  w_btag;
  logic [ADDR_W-1:0] w_blk;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [DATA_W-1:0] w_hit_word;
  logic [WAY_W-1:0]  w_victim;
  logic              w_found;
  logic              w_idle, w_rd_hit, w_rd_miss, w_wr;
  logic              w_fill_beat, w_fill_last;

  assign w_tag  = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign w_idx  = bus.req_addr[OFF_W +: IDX_W];
  assign w_wsel = bus.req_addr[1 +: WSEL_W];
  assign w_blk  = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_bidx = r_base[OFF_W +: IDX_W];
  assign w_btag = r_base[ADDR_W-1 -: TAG_W];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    w_hit_word = r_data[w_hit_way][{w_idx, w_wsel}];
  end

  // Lowest-numbered invalid way wins; the LRU pointer only matters once the set is full.
  always_comb begin
    w_victim = '0;
    w_found  = 1'b0;
    if (WAYS > 1) w_victim = WAY_W'(r_lru[w_idx]);
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_found && !r_valid[w][w_idx]) begin
        w_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
  end

  assign w_idle      = (r_state == S_IDLE);
  assign w_rd_hit    = w_idle & bus.req_valid & ~bus.req_we & w_hit;
  assign w_rd_miss   = w_idle & bus.req_valid & ~bus.req_we & ~w_hit;
  assign w_wr        = w_idle & bus.req_valid & bus.req_we;
  assign w_fill_beat = (r_state == S_FILL) & bus.mem_data_valid;
  assign w_fill_last = w_fill_beat & (r_beat == LASTW);

  assign bus.stall       = ~rst & ((r_state == S_FILL) | w_rd_miss);
  assign bus.rd_data     = (w_rd_hit & ~rst) ? w_hit_word : '0;
  assign bus.mem_wr_en   = w_wr & ~rst;
  assign bus.mem_wr_addr = (w_wr & ~rst) ? bus.req_addr : '0;
  assign bus.mem_wr_data = (w_wr & ~rst) ? bus.req_wdata : '0;
  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.mem_rd_addr = r_mem_rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_victim      <= '0;
      r_issue       <= '0;
      r_beat        <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_lru[s] <= 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_miss) begin
            r_state       <= S_FILL;
            r_base        <= w_blk;
            r_victim      <= w_victim;
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= w_blk;
            r_issue       <= CNT_W'(1);
            r_beat        <= '0;
          end
          if ((w_rd_hit || (w_wr && w_hit)) && (WAYS > 1)) r_lru[w_idx] <= ~w_hit_way[0];
        end
        S_FILL: begin
          if (r_issue < NWORDS) begin
            r_mem_rd_addr <= r_base + ADDR_W'({r_issue, 1'b0});
            r_issue       <= r_issue + 1'b1;
          end else begin
            r_mem_rd_en <= 1'b0;
          end
          if (w_fill_beat) begin
            r_beat <= r_beat + 1'b1;
            if (w_fill_last) begin
              r_state                  <= S_IDLE;
              r_beat                   <= '0;
              r_mem_rd_en              <= 1'b0;
              r_valid[r_victim][w_bidx] <= 1'b1;
              if (WAYS > 1) r_lru[w_bidx] <= ~r_victim[0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array contents survive reset; only the valid bits above are cleared.
  always_ff @(posedge clk) begin
    if (w_fill_beat)
      r_data[r_victim][{w_bidx, r_beat[WSEL_W-1:0]}] <= bus.mem_rdata;
    else if (w_wr && w_hit)
      r_data[w_hit_way][{w_idx, w_wsel}] <= bus.req_wdata;
    if (w_fill_last) r_tag[r_victim][w_bidx] <= w_btag;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_rd_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (w_rd_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: recency-list cache model, golden memory image,
// latency-4 memory responder and a per-cycle output monitor.
module tb_assoc_cache;
  localparam int LAT       = 4;
  localparam int WORDS     = 8;
  localparam int STALL_CYC = LAT + WORDS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  assoc_cache_if #(.ADDR_W(16), .DATA_W(16)) bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  assoc_cache #(.ADDR_W(16), .DATA_W(16), .SETS(64), .WORDS(8), .WAYS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory images ----------------
  logic [15:0] gold_ovr [int];
  logic [15:0] dev_ovr  [int];

  function automatic int wkey(input logic [15:0] a);
    return int'({a[15:1], 1'b0});
  endfunction

  function automatic logic [15:0] init_word(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:1], 1'b0};
    return {w[7:0], w[15:8]} ^ 16'h3C3C;
  endfunction

  function automatic logic [15:0] gold_word(input logic [15:0] a);
    if (gold_ovr.exists(wkey(a))) return gold_ovr[wkey(a)];
    return init_word(a);
  endfunction

  function automatic logic [15:0] dev_word(input logic [15:0] a);
    if (dev_ovr.exists(wkey(a))) return dev_ovr[wkey(a)];
    return init_word(a);
  endfunction

  // ---------------- cache model: per-set recency list ----------------
  int          m_cnt [64];
  logic [5:0]  m_mru [64];
  logic [5:0]  m_lru [64];
  int          m_hits   = 0;
  int          m_misses = 0;

  function automatic bit model_hit(input logic [15:0] a);
    int s = int'(a[9:4]);
    return (m_cnt[s] >= 1 && m_mru[s] == a[15:10]) || (m_cnt[s] == 2 && m_lru[s] == a[15:10]);
  endfunction

  task automatic model_touch(input logic [15:0] a, input bit allocate);
    int s = int'(a[9:4]);
    logic [5:0] t = a[15:10];
    if (model_hit(a)) begin
      if (m_mru[s] != t) begin
        m_lru[s] = m_mru[s];
        m_mru[s] = t;
      end
    end else if (allocate) begin
      if (m_cnt[s] > 0) m_lru[s] = m_mru[s];
      m_mru[s] = t;
      if (m_cnt[s] < 2) m_cnt[s]++;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // ---------------- memory responder ----------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;
  pend_t       pend_q [$];
  logic [15:0] rd_log [$];
  int          beats     = 0;
  int          wr_pulses = 0;
  bit          spurious  = 0;

  always @(negedge clk) begin
    if (bus.mem_rd_en) begin
      pend_q.push_back('{bus.mem_rd_addr, cyc + LAT});
      rd_log.push_back(bus.mem_rd_addr);
    end
    if (bus.mem_wr_en) begin
      dev_ovr[wkey(bus.mem_wr_addr)] = bus.mem_wr_data;
      wr_pulses++;
    end
  end

  always @(posedge clk) begin : responder
    pend_t p;
    cyc = cyc + 1;
    #1;
    if (rst) begin
      pend_q.delete();
      bus.mem_data_valid = 1'b0;
      bus.mem_rdata      = '0;
    end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      bus.mem_data_valid = 1'b1;
      bus.mem_rdata      = dev_word(p.addr);
      beats++;
    end else if (spurious) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_rdata      = 16'hDEAD;
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_rdata      = '0;
    end
  end

  // ---------------- per-cycle monitor ----------------
  int          act_kind = 0;   // 0 idle, 1 read, 2 write
  int          t0       = 0;
  bit          exp_miss = 0;
  logic [15:0] exp_base = '0;
  logic [15:0] exp_addr = '0;
  logic [15:0] exp_wdat = '0;

  always @(negedge clk) begin : mon
    int el;
    bit es;
    bit er;
    if (rst) begin
      check("rst_stall", bus.stall, 0);
      check("rst_mem_rd_en", bus.mem_rd_en, 0);
      check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
      check("rst_mem_wr_en", bus.mem_wr_en, 0);
      check("rst_mem_wr_addr", bus.mem_wr_addr, 0);
      check("rst_mem_wr_data", bus.mem_wr_data, 0);
      check("rst_rd_data", bus.rd_data, 0);
    end else if (act_kind == 1) begin
      el = cyc - t0;
      es = exp_miss && (el < STALL_CYC);
      er = exp_miss && (el >= 1) && (el <= WORDS);
      check("stall", bus.stall, 32'(es));
      check("mem_rd_en", bus.mem_rd_en, 32'(er));
      check("rd_mem_wr_en", bus.mem_wr_en, 0);
      if (er) check("mem_rd_addr", bus.mem_rd_addr, 32'(exp_base + 16'((el - 1) * 2)));
      if (!es) begin
        check("rd_data", bus.rd_data, gold_word(exp_addr));
        m_hits++;
      end
    end else if (act_kind == 2) begin
      check("wr_stall", bus.stall, 0);
      check("mem_wr_en", bus.mem_wr_en, 1);
      check("mem_wr_addr", bus.mem_wr_addr, exp_addr);
      check("mem_wr_data", bus.mem_wr_data, exp_wdat);
      check("wr_mem_rd_en", bus.mem_rd_en, 0);
    end else begin
      check("idle_stall", bus.stall, 0);
      check("idle_mem_rd_en", bus.mem_rd_en, 0);
      check("idle_mem_wr_en", bus.mem_wr_en, 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic launch_read(input logic [15:0] a);
    @(posedge clk); #1;
    exp_miss = !model_hit(a);
    if (exp_miss) m_misses++;
    exp_base = {a[15:4], 4'h0};
    exp_addr = a;
    t0       = cyc;
    act_kind = 1;
    rd_log.delete();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
  endtask

  task automatic do_read(input logic [15:0] a, output int stalls, output logic [15:0] data);
    launch_read(a);
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
    end
    check("read_completes", bus.stall, 0);
    data = bus.rd_data;
    @(posedge clk); #1;
    act_kind      = 0;
    bus.req_valid = 1'b0;
    model_touch(a, 1'b1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    exp_addr = a;
    exp_wdat = d;
    act_kind = 2;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    @(posedge clk); #1;
    act_kind      = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    gold_ovr[wkey(a)] = d;
    if (model_hit(a)) model_touch(a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          st;
    int          wp;
    logic [15:0] rd;
    bus.req_valid      = 1'b0;
    bus.req_we         = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_rdata      = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_stall", bus.stall, 0);

    // Cold miss and fill of block 0x1230
    do_read(16'h1234, st, rd);
    check("miss_stall_cycles", st, STALL_CYC);
    check("miss_rd_data", rd, 16'h082E);
    check("fill_rd_count", rd_log.size(), WORDS);
    check("fill_first_addr", rd_log[0], 16'h1230);
    check("fill_last_addr", rd_log[WORDS-1], 16'h123E);

    do_read(16'h1236, st, rd);
    check("hit_stall_cycles", st, 0);
    check("hit_rd_data", rd, 16'h0A2E);
    check("hit_no_mem_rd", rd_log.size(), 0);
`ifdef CACHE_STATS_EN
    check("hit_count_lit", hit_count, 2);
    check("miss_count_lit", miss_count, 1);
`endif

    // Replacement within set 0x23
    do_read(16'h5230, st, rd);
    check("other_way_miss", st, STALL_CYC);
    do_read(16'h1230, st, rd);
    check("mru_touch_hit", st, 0);
    do_read(16'h9230, st, rd);
    check("evict_fill_miss", st, STALL_CYC);
    do_read(16'h1230, st, rd);
    check("survivor_hit", st, 0);
    do_read(16'h5230, st, rd);
    check("evicted_misses", st, STALL_CYC);

    // Write-through on hit and on miss
    wp = wr_pulses;
    do_write(16'h1232, 16'hBEEF);
    check("wr_hit_pulses", wr_pulses - wp, 1);
    do_read(16'h1232, st, rd);
    check("wr_hit_read_stall", st, 0);
    check("wr_hit_read_data", rd, 16'hBEEF);
    wp = wr_pulses;
    do_write(16'h7000, 16'h1111);
    check("wr_miss_pulses", wr_pulses - wp, 1);
    do_read(16'h7000, st, rd);
    check("wr_miss_no_alloc", st, STALL_CYC);
    check("wr_miss_read_data", rd, 16'h1111);
`ifdef CACHE_STATS_EN
    check("hit_count_model", hit_count, 32'(m_hits));
    check("miss_count_model", miss_count, 32'(m_misses));
`endif

    // Reset after the third beat of a fill
    launch_read(16'h2468);
    beats = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beats >= 3) break;
    end
    check("abort_beats_seen", beats, 3);
    @(posedge clk); #1;
    rst           = 1'b1;
    act_kind      = 0;
    bus.req_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_stall", bus.stall, 0);

    do_read(16'h1232, st, rd);
    check("post_rst_miss", st, STALL_CYC);
    check("post_rst_data", rd, 16'hBEEF);
    do_read(16'h2468, st, rd);
    check("refill_stall", st, STALL_CYC);
    check("refill_data", rd, 16'h5418);

    // Stray memory beats while idle must not disturb the cache
    @(negedge clk);
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    do_read(16'h2468, st, rd);
    check("spurious_hit", st, 0);
    check("spurious_data", rd, 16'h5418);
    do_read(16'h246E, st, rd);
    check("spurious_other_word", rd, init_word(16'h246E));
`ifdef CACHE_STATS_EN
    check("final_hit_count", hit_count, 32'(m_hits));
    check("final_miss_count", miss_count, 32'(m_misses));
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Parameter DATA_W, default 16, word width; byte offset within a word is 1 bit.
REQ-003 Parameter SETS, default 64, number of sets; power of 2.
REQ-004 Parameter WORDS, default 8, words per block; power of 2.
REQ-005 Parameter WAYS, default 2, associativity; legal values are 1 and 2 only.
REQ-006 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port req_valid, input, 1, access request present.
REQ-009 Port req_we, input, 1, 1 = write, 0 = read.
REQ-010 Port req_addr, input, ADDR_W, byte address split as {tag, index, offset}; offset = log2(WORDS)+1 bits, index = log2(SETS) bits.
REQ-011 Port req_wdata, input, DATA_W, write data.
REQ-012 Port rd_data, output, DATA_W, read data; valid when req_valid=1, req_we=0 and stall=0.
REQ-013 Port stall, output, 1, requester holds the request unchanged while high.
REQ-014 Port mem_rd_en, output, 1, memory read request, one word per cycle.
REQ-015 Port mem_rd_addr, output, ADDR_W, word-aligned memory read address.
REQ-016 Port mem_data_valid, input, 1, returned fill word present; words return in request order, latency at least 1 cycle.
REQ-017 Port mem_rdata, input, DATA_W, returned fill word.
REQ-018 Port mem_wr_en, output, 1, write-through pulse.
REQ-019 Port mem_wr_addr, output, ADDR_W, write-through address.
REQ-020 Port mem_wr_data, output, DATA_W, write-through data.

Function
REQ-021 Lookup is combinational: hit = valid and tag match in any way of the indexed set; rd_data is the hit way's word, selected by req_addr[offset-1:1].
REQ-022 stall = req_valid & ~req_we & ~hit while in IDLE, and is forced to 1 in FILL.
REQ-023 FSM states: IDLE and FILL. IDLE->FILL on a read miss; FILL->IDLE on the cycle the WORDS-th mem_data_valid beat is absorbed.
REQ-024 On entry to FILL, latch the block base (req_addr with offset zeroed) and the victim way: an invalid way if one exists (way 0 first), otherwise the LRU way.
REQ-025 In FILL, assert mem_rd_en for exactly WORDS consecutive cycles with mem_rd_addr = base + 2*i, i = 0..WORDS-1; the issue counter is log2(WORDS)+1 bits.
REQ-026 Each mem_data_valid beat k writes mem_rdata into word k of the victim way; tag and valid are written with the last beat.
REQ-027 The cycle after FILL->IDLE, the held request re-looks-up, hits, and stall deasserts; read-miss latency = memory latency + WORDS + 1 cycles.
REQ-028 Write (req_we=1, req_valid=1) in IDLE: mem_wr_en pulses that cycle with req_addr and req_wdata; on hit, the word is updated at the clock edge; on miss, no allocation; stall stays 0.
REQ-029 Requests in FILL are ignored (no write-through, no LRU update) until stall drops.
REQ-030 LRU, 1 bit per set when WAYS=2: set to point at the other way on every hit (read or write) and on fill completion; unused when WAYS=1.
REQ-031 mem_data_valid outside FILL, or beyond WORDS beats, is ignored.

Reset
REQ-032 rst clears all valid bits, LRU bits, counters, and forces state IDLE; an in-progress fill is abandoned.
REQ-033 During and immediately after reset: stall=0, mem_rd_en=0, mem_wr_en=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0, rd_data=0; data array contents are not reset.

Configuration
REQ-034 Macro CACHE_STATS_EN defined: add outputs hit_count and miss_count (32 bits each, reset to 0, wrapping); hit_count increments once per accepted read-hit cycle; miss_count increments on each IDLE->FILL transition.
REQ-035 CACHE_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Verification
REQ-036 Defaults, memory latency 4: read 0x1234 after reset -> stall for 4+8+1 cycles, mem_rd_addr 0x1230..0x123E in 8 cycles, then rd_data = the word returned for 0x1234.
REQ-037 Read 0x1236 right after that fill -> hit, stall=0, no mem_rd_en.
REQ-038 Fill 0x1230, then 0x5230 (same index, other way), read 0x1230, then fill 0x9230 -> 0x5230's way is evicted; 0x1230 still hits.
REQ-039 Write 0xBEEF to 0x1232 (hit) -> mem_wr_en one cycle at 0x1232; the next read of 0x1232 returns 0xBEEF; write to uncached 0x7000 -> mem_wr_en pulses, a read of 0x7000 still misses.
REQ-040 Assert rst after the 3rd fill beat -> state IDLE, stall=0, all reads miss; a new fill completes correctly.
REQ-041 CACHE_STATS_EN defined, sequence of REQ-036 and REQ-037 -> miss_count=1, hit_count=2 (post-fill hit plus the 0x1236 hit).
